// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES types and constants for the key schedule and round datapath.
//   aes_word   : 32-bit AES word (four bytes, MSB byte first)
//   key_128    : 128-bit key / round key, word [0] in bits [127:96]
//   NR_AES128  : number of AES-128 rounds
//   RCON       : round constants, indexed 1..10
//   SBOX       : forward AES S-box
// -----------------------------------------------------------------------------
package aes_pkg;

   typedef logic [31:0]  aes_word;
   typedef logic [127:0] key_128;

   localparam int NR_AES128 = 10;

   localparam logic [7:0] RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Forward S-box substitution of one byte.
   function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
      return SBOX[b];
   endfunction

   // Round constant for round rnd; rounds outside 1..10 yield zero.
   function automatic logic [7:0] rcon_lookup(input logic [3:0] rnd);
      if ((rnd >= 4'd1) && (rnd <= 4'd10)) begin
         return RCON[rnd];
      end else begin
         return 8'h00;
      end
   endfunction

   // Extract word idx of a key; word 0 is the most significant word.
   function automatic aes_word key_word(input key_128 k, input logic [1:0] idx);
      aes_word w;
      case (idx)
         2'd0:    w = k[127:96];
         2'd1:    w = k[95:64];
         2'd2:    w = k[63:32];
         2'd3:    w = k[31:0];
         default: w = 32'd0;
      endcase
      return w;
   endfunction

   // Cyclic left rotate by one byte (not a shift: the top byte wraps around).
   function automatic aes_word rot_word(input aes_word w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_sub_word.sv
// -----------------------------------------------------------------------------
// aes_sub_word
// Combinational SubWord: applies the AES S-box to each byte of one word.
// Shared between the key schedule and the cipher SubBytes stage.
//   w_i : input word
//   w_o : byte-wise substituted word
// -----------------------------------------------------------------------------
module aes_sub_word
   import aes_pkg::*;
(
   input  aes_word w_i,
   output aes_word w_o
);

   assign w_o = {sbox_lookup(w_i[31:24]),
                 sbox_lookup(w_i[23:16]),
                 sbox_lookup(w_i[15:8]),
                 sbox_lookup(w_i[7:0])};

endmodule

// File: rtl/aes_round_key_store.sv
// -----------------------------------------------------------------------------
// aes_round_key_store
// Expands a 128-bit AES cipher key into the 11 AES-128 round keys, one per
// clock, stores them in an internal buffer and serves them by index through a
// registered read port.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   key_valid  : cipher key offered on key_i
//   key_ready  : block can accept a new cipher key
//   key_i      : cipher key, word 0 in bits [127:96]
//   rk_addr    : round-key index 0..10 (11..15 read as zero)
//   rk_o       : registered round key, one cycle after rk_addr
//   keys_ready : all round keys of the last accepted key are valid
//   busy       : expansion in progress
// -----------------------------------------------------------------------------
module aes_round_key_store
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         key_valid,
   output logic         key_ready,
   input  key_128       key_i,
   input  logic [3:0]   rk_addr,
   output key_128       rk_o,
   output logic         keys_ready,
   output logic         busy
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_EXPAND = 2'd1;
   localparam logic [1:0] ST_VALID  = 2'd2;

   localparam logic [3:0] NR_IDX    = 4'(NR_AES128);

   logic [1:0] state_q, state_d;
   logic [3:0] rnd_q, rnd_d;
   key_128     prev_q, prev_d;
   key_128     rk_q, rk_d;
   logic       key_ready_q, keys_ready_q, busy_q;

   key_128     buf_q [0:10];

   logic       wr_en_s;
   logic [3:0] wr_idx_s;
   key_128     wr_data_s;

   aes_word    rot_s;
   aes_word    sub_s;
   aes_word    t_s;
   aes_word    n0_s, n1_s, n2_s, n3_s;
   key_128     next_key_s;

   assign rot_s = rot_word(key_word(prev_q, 2'd3));

   aes_sub_word u_sub_word (
      .w_i (rot_s),
      .w_o (sub_s)
   );

   // One key-schedule step from the previous round key.
   always_comb begin
      t_s        = sub_s ^ {rcon_lookup(rnd_q), 24'h000000};
      n0_s       = key_word(prev_q, 2'd0) ^ t_s;
      n1_s       = key_word(prev_q, 2'd1) ^ n0_s;
      n2_s       = key_word(prev_q, 2'd2) ^ n1_s;
      n3_s       = key_word(prev_q, 2'd3) ^ n2_s;
      next_key_s = {n0_s, n1_s, n2_s, n3_s};
   end

   // Next-state, round counter and buffer-write control.
   always_comb begin
      state_d   = state_q;
      rnd_d     = rnd_q;
      prev_d    = prev_q;
      wr_en_s   = 1'b0;
      wr_idx_s  = 4'd0;
      wr_data_s = 128'd0;
      case (state_q)
         ST_IDLE, ST_VALID: begin
            if (key_valid) begin
               wr_en_s   = 1'b1;
               wr_idx_s  = 4'd0;
               wr_data_s = key_i;
               prev_d    = key_i;
               rnd_d     = 4'd1;
               state_d   = ST_EXPAND;
            end else begin
               state_d   = state_q;
            end
         end
         ST_EXPAND: begin
            wr_en_s   = 1'b1;
            wr_idx_s  = rnd_q;
            wr_data_s = next_key_s;
            prev_d    = next_key_s;
            if (rnd_q == NR_IDX) begin
               rnd_d   = 4'd0;
               state_d = ST_VALID;
            end else begin
               rnd_d   = rnd_q + 4'd1;
               state_d = ST_EXPAND;
            end
         end
         default: begin
            state_d = ST_IDLE;
            rnd_d   = 4'd0;
         end
      endcase
      // A reset edge aborts the expansion without touching the buffer.
      if (rst) begin
         wr_en_s = 1'b0;
      end else begin
         wr_en_s = wr_en_s;
      end
   end

   // Read-port selection; out-of-range indices return zero.
   always_comb begin
      if (rk_addr <= NR_IDX) begin
         rk_d = buf_q[rk_addr];
      end else begin
         rk_d = 128'd0;
      end
   end

   // FSM state, schedule registers and status flags decoded from next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         rnd_q        <= 4'd0;
         prev_q       <= 128'd0;
         key_ready_q  <= 1'b1;
         keys_ready_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rnd_q        <= rnd_d;
         prev_q       <= prev_d;
         key_ready_q  <= (state_d != ST_EXPAND);
         keys_ready_q <= (state_d == ST_VALID);
         busy_q       <= (state_d == ST_EXPAND);
      end
   end

   // Round-key buffer; intentionally not cleared by reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         buf_q[wr_idx_s] <= wr_data_s;
      end
   end

   // Registered read port; a same-cycle write is seen one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         rk_q <= 128'd0;
      end else begin
         rk_q <= rk_d;
      end
   end

   assign key_ready  = key_ready_q;
   assign keys_ready = keys_ready_q;
   assign busy       = busy_q;
   assign rk_o       = rk_q;

endmodule

// File: tb/tb_aes_round_key_store.sv
// -----------------------------------------------------------------------------
// tb_aes_round_key_store
// Directed self-checking bench for aes_round_key_store using FIPS-197 vectors.
// -----------------------------------------------------------------------------
module tb_aes_round_key_store;
   import aes_pkg::*;

   localparam key_128 KEY_A1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam key_128 RK_A1_1   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam key_128 RK_A1_10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam key_128 KEY_ZERO  = 128'h00000000000000000000000000000000;
   localparam key_128 RK_Z_1    = 128'h62636363626363636263636362636363;
   localparam key_128 RK_Z_10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_valid;
   logic       key_ready;
   key_128     key_i;
   logic [3:0] rk_addr;
   key_128     rk_o;
   logic       keys_ready;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   aes_round_key_store dut (
      .clk        (clk),
      .rst        (rst),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .key_i      (key_i),
      .rk_addr    (rk_addr),
      .rk_o       (rk_o),
      .keys_ready (keys_ready),
      .busy       (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until keys_ready rises; gives up at 20.
   task automatic wait_keys_ready(output int cycles);
      cycles = 0;
      while (cycles < 20) begin
         tick();
         cycles++;
         if (keys_ready === 1'b1) break;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; key_valid = 1'b0; key_i = KEY_ZERO; rk_addr = 4'd0;
      tick();
      rst = 1'b0;
      n_checks++; if (rk_o !== 128'd0) $display("FAIL reset_rk_o got %h expected %h", rk_o, 128'd0); else n_pass++;
      n_checks++; if (keys_ready !== 1'b0) $display("FAIL reset_keys_ready got %b expected 0", keys_ready); else n_pass++;
      n_checks++; if (key_ready !== 1'b1) $display("FAIL reset_key_ready got %b expected 1", key_ready); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy); else n_pass++;
   endtask

   task automatic test_a1_load();
      int c;
      key_i = KEY_A1; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      n_checks++; if (busy !== 1'b1) $display("FAIL a1_busy got %b expected 1", busy); else n_pass++;
      n_checks++; if (key_ready !== 1'b0) $display("FAIL a1_key_ready got %b expected 0", key_ready); else n_pass++;
      wait_keys_ready(c);
      n_checks++; if (c !== 10) $display("FAIL a1_latency got %0d expected 10", c); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL a1_busy_done got %b expected 0", busy); else n_pass++;
      n_checks++; if (key_ready !== 1'b1) $display("FAIL a1_key_ready_done got %b expected 1", key_ready); else n_pass++;
      rk_addr = 4'd0; tick();
      n_checks++; if (rk_o !== KEY_A1) $display("FAIL a1_rk0 got %h expected %h", rk_o, KEY_A1); else n_pass++;
      rk_addr = 4'd1; tick();
      n_checks++; if (rk_o !== RK_A1_1) $display("FAIL a1_rk1 got %h expected %h", rk_o, RK_A1_1); else n_pass++;
      rk_addr = 4'd10; tick();
      n_checks++; if (rk_o !== RK_A1_10) $display("FAIL a1_rk10 got %h expected %h", rk_o, RK_A1_10); else n_pass++;
   endtask

   task automatic test_reload_in_valid();
      int c;
      rk_addr = 4'd0; key_i = KEY_ZERO; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      n_checks++; if (keys_ready !== 1'b0) $display("FAIL reload_keys_ready_fall got %b expected 0", keys_ready); else n_pass++;
      // Entry 0 was written on the same edge: the read returns the old key.
      n_checks++; if (rk_o !== KEY_A1) $display("FAIL reload_rd_old got %h expected %h", rk_o, KEY_A1); else n_pass++;
      wait_keys_ready(c);
      n_checks++; if (c !== 10) $display("FAIL reload_latency got %0d expected 10", c); else n_pass++;
      rk_addr = 4'd10; tick();
      n_checks++; if (rk_o !== RK_Z_10) $display("FAIL reload_rk10 got %h expected %h", rk_o, RK_Z_10); else n_pass++;
      rk_addr = 4'd1; tick();
      n_checks++; if (rk_o !== RK_Z_1) $display("FAIL reload_rk1 got %h expected %h", rk_o, RK_Z_1); else n_pass++;
      rk_addr = 4'd0; tick();
      n_checks++; if (rk_o !== KEY_ZERO) $display("FAIL reload_rk0 got %h expected %h", rk_o, KEY_ZERO); else n_pass++;
   endtask

   task automatic test_reset_mid_expand();
      int c;
      key_i = KEY_A1; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b expected 0", busy); else n_pass++;
      n_checks++; if (key_ready !== 1'b1) $display("FAIL abort_key_ready got %b expected 1", key_ready); else n_pass++;
      n_checks++; if (keys_ready !== 1'b0) $display("FAIL abort_keys_ready got %b expected 0", keys_ready); else n_pass++;
      rk_addr = 4'd10; tick();
      n_checks++; if (keys_ready !== 1'b0) $display("FAIL abort_keys_ready_stays got %b expected 0", keys_ready); else n_pass++;
      // Entry 10 was never reached, so it still holds the previous schedule.
      n_checks++; if (rk_o !== RK_Z_10) $display("FAIL abort_stale_rk10 got %h expected %h", rk_o, RK_Z_10); else n_pass++;
      rk_addr = 4'd1; tick();
      n_checks++; if (rk_o !== RK_A1_1) $display("FAIL abort_partial_rk1 got %h expected %h", rk_o, RK_A1_1); else n_pass++;
      key_i = KEY_A1; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      wait_keys_ready(c);
      n_checks++; if (c !== 10) $display("FAIL abort_reload_latency got %0d expected 10", c); else n_pass++;
      rk_addr = 4'd10; tick();
      n_checks++; if (rk_o !== RK_A1_10) $display("FAIL abort_reload_rk10 got %h expected %h", rk_o, RK_A1_10); else n_pass++;
   endtask

   task automatic test_ignore_during_expand();
      int c;
      key_i = KEY_A1; key_valid = 1'b1;
      tick();
      key_i = KEY_ZERO;  // valid stays high with a different key
      wait_keys_ready(c);
      key_valid = 1'b0;
      n_checks++; if (c !== 10) $display("FAIL ignore_latency got %0d expected 10", c); else n_pass++;
      rk_addr = 4'd10; tick();
      n_checks++; if (rk_o !== RK_A1_10) $display("FAIL ignore_rk10 got %h expected %h", rk_o, RK_A1_10); else n_pass++;
      rk_addr = 4'd1; tick();
      n_checks++; if (rk_o !== RK_A1_1) $display("FAIL ignore_rk1 got %h expected %h", rk_o, RK_A1_1); else n_pass++;
      key_i = KEY_ZERO; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      n_checks++; if (keys_ready !== 1'b0) $display("FAIL second_key_accept got %b expected 0", keys_ready); else n_pass++;
      wait_keys_ready(c);
      n_checks++; if (c !== 10) $display("FAIL second_key_latency got %0d expected 10", c); else n_pass++;
      rk_addr = 4'd10; tick();
      n_checks++; if (rk_o !== RK_Z_10) $display("FAIL second_key_rk10 got %h expected %h", rk_o, RK_Z_10); else n_pass++;
   endtask

   task automatic test_addr_range();
      for (int a = 11; a <= 15; a++) begin
         rk_addr = 4'(a);
         tick();
         n_checks++; if (rk_o !== 128'd0) $display("FAIL addr_oor_%0d got %h expected %h", a, rk_o, 128'd0); else n_pass++;
      end
      rk_addr = 4'd1; tick();
      n_checks++; if (rk_o !== RK_Z_1) $display("FAIL latency_rk1 got %h expected %h", rk_o, RK_Z_1); else n_pass++;
      rk_addr = 4'd10; #1;
      n_checks++; if (rk_o !== RK_Z_1) $display("FAIL latency_hold got %h expected %h", rk_o, RK_Z_1); else n_pass++;
      tick();
      n_checks++; if (rk_o !== RK_Z_10) $display("FAIL latency_rk10 got %h expected %h", rk_o, RK_Z_10); else n_pass++;
   endtask

   initial begin
      rst = 1'b1; key_valid = 1'b0; key_i = KEY_ZERO; rk_addr = 4'd0;
      test_reset();
      test_a1_load();
      test_reload_in_valid();
      test_reset_mid_expand();
      test_ignore_during_expand();
      test_addr_range();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/aes_round_key_store.md
# aes_round_key_store

- Expands a 128-bit AES cipher key into all 11 round keys, one round key per clock, using an internal SubWord unit and Rcon sequencing.
- Holds the round keys in an on-block buffer and serves them through a registered read port.
- Sits between the key load interface and the cipher/inverse-cipher round datapath; the round datapath reads its round key by index instead of recomputing the schedule each block.

## Interface
- NR, 10, number of rounds; buffer holds NR+1 round keys (only 10 supported).
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  cipher key offered on key_i.
- key_ready  out  1  block can accept a new cipher key.
- key_i  in  128 (aes_pkg::key_128)  cipher key; word [0] = first 32 bits of FIPS-197 key.
- rk_addr  in  4  round-key index, 0..NR.
- rk_o  out  128 (aes_pkg::key_128)  registered round key for rk_addr.
- keys_ready  out  1  all NR+1 round keys for the last accepted key are valid.
- busy  out  1  expansion in progress.

## Operation
- FSM states: IDLE, EXPAND, VALID.
  - IDLE: key_ready=1, keys_ready=0, busy=0.
  - EXPAND: key_ready=0, busy=1, keys_ready=0.
  - VALID: key_ready=1, keys_ready=1, busy=0.
- Accept: key_valid && key_ready at a rising edge.
  - Write key_i to entry 0, load prev <= key_i, set rnd <= 1, go to EXPAND.
  - Legal from IDLE or VALID. In VALID, keys_ready drops the cycle after accept.
- EXPAND, each cycle:
  - t = SubWord(RotWord(prev[3])) ^ {Rcon[rnd], 24'h0}.
  - next[0] = prev[0]^t; next[1] = prev[1]^next[0]; next[2] = prev[2]^next[1]; next[3] = prev[3]^next[2].
  - Write next to entry rnd; prev <= next; rnd <= rnd+1.
  - When rnd==NR: write entry NR, go to VALID.
- RotWord(w) = {w[23:0], w[31:24]}; this is a rotate, not a shift.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- key_valid during EXPAND: ignored (key_ready=0); expansion is not restarted.
- Read port:
  - rk_o <= buffer[rk_addr] every cycle, independent of state.
  - rk_addr > NR: rk_o <= 0.
  - Reads during EXPAND return current buffer contents; consumers gate on keys_ready.
- All XOR arithmetic is 32-bit per word; no carries.

## Timing
- Reset (rst=1 at an edge):
  - State <= IDLE; rnd <= 0; rk_o <= 0.
  - Outputs: key_ready=1, keys_ready=0, busy=0.
  - Buffer contents are not cleared.
- Reset mid-EXPAND: aborts immediately; the next cycle is IDLE with keys_ready=0; the partial buffer is stale.
- Accept at edge T:
  - Entry 0 is written at T.
  - Entries 1..10 are written at edges T+1..T+10.
  - keys_ready=1 in the cycle after edge T+10 (11 cycles key-to-ready).
- rk_o latency: 1 cycle from rk_addr.
  - A read of entry k in the same cycle entry k is written returns the old value.
- key_ready, keys_ready, busy are decoded from registered state only, with no combinational path from inputs.

## Structure
- aes_pkg:
  - key_128 and aes_word typedefs, already present.
  - Add the Rcon constant array, indexed 1..10.
  - Add NR_AES128 = 10.
- Sub-module aes_sub_word: combinational, four S-box lookups on one aes_word.
  - Reusable by the cipher's SubBytes stage.
- Buffer: 11 × 128-bit register array, written only by the FSM.

## Test plan
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c:
  - keys_ready 11 cycles after accept.
  - rk_addr=0 -> 2b7e151628aed2a6abf7158809cf4f3c.
  - rk_addr=1 -> a0fafe1788542cb123a339392a6c7605.
  - rk_addr=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- Reset sequence -> rk_o=0, keys_ready=0, key_ready=1, busy=0 the cycle after rst.
- Assert rst at EXPAND cycle 5:
  - -> IDLE next cycle, keys_ready stays 0.
  - A new A.1 load then yields correct round 10 key.
- key_valid held high during EXPAND with a different key -> ignored; A.1 round keys unchanged; second key accepted only after VALID.
- In VALID, load all-zero key -> keys_ready falls next cycle; 11 cycles later rk_addr=10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
- rk_addr=11..15 -> rk_o=0; rk_addr change -> rk_o updates exactly one cycle later.
